// File: rtl/rx_event_monitor.sv
// Receiver event counters with snapshot readout, plus a stretched receiver reset and hold-off on request.
// Optional macro RX_EVENT_MONITOR_TIMESTAMP_EN adds a free-running timestamp of the last reset.
module rx_event_monitor #(
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 22,
  parameter int SEL_WIDTH     = 4,
  parameter int RST_PULSE_LEN = 4,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_EVENTS-1:0]    event_in,
  input  logic [NUM_EVENTS-1:0]    event_enable_mask,
  input  logic [NUM_EVENTS-1:0]    rst_request_mask,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
  input  logic                     counter_clear,
  input  logic                     snapshot_req,
  input  logic [SEL_WIDTH-1:0]     counter_sel,
  output logic [COUNTER_WIDTH-1:0] counter_out,
  output logic                     snapshot_valid,
  output logic                     receiver_rst,
  output logic                     rst_busy,
  output logic [COUNTER_WIDTH-1:0] suppressed_count,
  output logic [31:0]              last_rst_ts
);

  localparam int PULSE_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RST_PULSE = 2'd1,
    HOLDOFF   = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [PULSE_W-1:0]       pulse_cnt;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;
  logic                     rst_nxt;
  logic                     busy_nxt;

  logic [NUM_EVENTS-1:0]    count_en;
  logic                     req;
  logic                     busy;
  logic                     suppress;
  logic [COUNTER_WIDTH-1:0] live   [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] shadow [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] sel_val;

  assign count_en = event_in & event_enable_mask;
  assign req      = |(event_in & rst_request_mask);
  assign busy     = (state != IDLE);
  assign suppress = req & busy;

  // Clear wins over the old value but not over a same-cycle event: clear then count.
  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        live[g] <= '0;
      end else if (counter_clear) begin
        live[g] <= count_en[g] ? COUNTER_WIDTH'(1) : '0;
      end else if (count_en[g] && (live[g] != CNT_MAX)) begin
        live[g] <= live[g] + COUNTER_WIDTH'(1);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        shadow[g] <= '0;
      end else if (snapshot_req) begin
        shadow[g] <= live[g];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snapshot_valid <= 1'b0;
    end else begin
      snapshot_valid <= snapshot_req;
    end
  end

  // Unpopulated selector codes read back as zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (counter_sel == SEL_WIDTH'(i)) begin
        sel_val = shadow[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_out <= '0;
    end else begin
      counter_out <= sel_val;
    end
  end

  // State register; receiver_rst and rst_busy are registered copies of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      receiver_rst <= 1'b0;
      rst_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      receiver_rst <= rst_nxt;
      rst_busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = RST_PULSE;
        end
      end
      RST_PULSE: begin
        if (pulse_cnt == '0) begin
          state_nxt = (holdoff_cycles != '0) ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rst_nxt  = (state_nxt == RST_PULSE);
    busy_nxt = (state_nxt != IDLE);
  end

  // Hold-off length is sampled on the pulse-to-holdoff edge so it cannot change mid-window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            pulse_cnt <= PULSE_W'(RST_PULSE_LEN - 1);
          end
        end
        RST_PULSE: begin
          if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
          end else begin
            hold_cnt <= holdoff_cycles - HOLDOFF_WIDTH'(1);
          end
        end
        HOLDOFF: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLDOFF_WIDTH'(1);
          end
        end
        default: begin
          pulse_cnt <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      suppressed_count <= '0;
    end else if (counter_clear) begin
      suppressed_count <= suppress ? COUNTER_WIDTH'(1) : '0;
    end else if (suppress && (suppressed_count != CNT_MAX)) begin
      suppressed_count <= suppressed_count + COUNTER_WIDTH'(1);
    end
  end

`ifdef RX_EVENT_MONITOR_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts          <= '0;
      last_rst_ts <= '0;
    end else begin
      ts <= ts + 32'd1;
      if ((state == IDLE) && req) begin
        last_rst_ts <= ts;
      end
    end
  end
`else
  assign last_rst_ts = '0;
`endif

endmodule
